// File: rtl/dac_spi_writer.sv
// -----------------------------------------------------------------------------
// dac_spi_writer
//   Output stage of the line-draw controller. Takes one (x, y, beam) sample per
//   valid/ready handshake and writes it to a dual-channel 12-bit SPI DAC as two
//   16-bit frames (X on channel A, then Y on channel B). A single LDAC strobe
//   then updates both DAC outputs and the beam pin together, so deflection and
//   beam state reach the CRT at the same time.
//
// Ports
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   x, y      in   12-bit sample, latched only at the handshake
//   beam_in   in   beam state for the sample, latched only at the handshake
//   valid     in   sample request
//   ready     out  block idle; a sample is taken when valid && ready at clk rise
//   cs_pin    out  DAC chip select, active low
//   clk_pin   out  SPI SCK, idle low (mode 0)
//   data_pin  out  SPI MOSI, MSB first
//   ldac_pin  out  DAC latch strobe, active low
//   beam_pin  out  registered beam output, updated with the LDAC strobe
// -----------------------------------------------------------------------------
module dac_spi_writer #(
   parameter int unsigned CLK_DIV = 2,     // system clocks per SCK half-period
   parameter int unsigned GAP     = 2,     // clocks CS is high between frames
   parameter int unsigned LDAC_W  = 2,     // clocks LDAC is held low
   parameter bit          BUF     = 1'b0,  // frame BUF bit
   parameter bit          GA_N    = 1'b1   // frame GA_n bit (1 = 1x gain)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] x,
   input  logic [11:0] y,
   input  logic        beam_in,
   input  logic        valid,
   output logic        ready,
   output logic        cs_pin,
   output logic        clk_pin,
   output logic        data_pin,
   output logic        ldac_pin,
   output logic        beam_pin
);

   // The single divider counter also times the GAP and LDAC intervals.
   localparam int unsigned CNT_MAX =
      (CLK_DIV > GAP) ? ((CLK_DIV > LDAC_W) ? CLK_DIV : LDAC_W)
                      : ((GAP > LDAC_W) ? GAP : LDAC_W);
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned BIT_W   = $clog2(16);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FRAME_A,
      S_GAP,
      S_FRAME_B,
      S_LDAC
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   div_cnt;
   logic [BIT_W-1:0]   bit_cnt;
   logic               phase;      // 0: SCK low half of a bit, 1: SCK high half
   logic [11:0]        x_q;
   logic [11:0]        y_q;
   logic               beam_q;

   logic [15:0]        cur_word;
   logic [BIT_W-1:0]   nxt_bit;

   // DAC command word: {channel, BUF, GA_n, SHDN_n=1, data}
   function automatic logic [15:0] frame_word(input logic ch, input logic [11:0] d);
      return {ch, BUF, GA_N, 1'b1, d};
   endfunction

   // Word currently being shifted out
   always_comb begin
      cur_word = frame_word(1'b0, x_q);
      if (state == S_FRAME_B) begin
         cur_word = frame_word(1'b1, y_q);
      end
   end

   assign nxt_bit = bit_cnt - BIT_W'(1);

   // Sequencer: all pin values are registered here for the following cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         phase    <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         beam_q   <= 1'b0;
         ready    <= 1'b0;
         cs_pin   <= 1'b1;
         clk_pin  <= 1'b0;
         data_pin <= 1'b0;
         ldac_pin <= 1'b1;
         beam_pin <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               ready <= 1'b1;
               if (valid && ready) begin
                  x_q      <= x;
                  y_q      <= y;
                  beam_q   <= beam_in;
                  ready    <= 1'b0;
                  state    <= S_FRAME_A;
                  cs_pin   <= 1'b0;
                  clk_pin  <= 1'b0;
                  data_pin <= 1'b0;   // MSB of frame A is the channel bit, 0
                  div_cnt  <= '0;
                  bit_cnt  <= BIT_W'(15);
                  phase    <= 1'b0;
               end
            end

            S_FRAME_A, S_FRAME_B: begin
               if (div_cnt == CNT_W'(CLK_DIV - 1)) begin
                  div_cnt <= '0;
                  if (!phase) begin
                     phase   <= 1'b1;
                     clk_pin <= 1'b1;
                  end else begin
                     phase   <= 1'b0;
                     clk_pin <= 1'b0;
                     if (bit_cnt == '0) begin
                        // Last bit done: SCK falls together with CS rising
                        cs_pin   <= 1'b1;
                        data_pin <= 1'b0;
                        if (state == S_FRAME_A) begin
                           state <= S_GAP;
                        end else begin
                           state    <= S_LDAC;
                           ldac_pin <= 1'b0;
                           beam_pin <= beam_q;
                        end
                     end else begin
                        bit_cnt  <= nxt_bit;
                        data_pin <= cur_word[nxt_bit];
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + CNT_W'(1);
               end
            end

            S_GAP: begin
               if (div_cnt == CNT_W'(GAP - 1)) begin
                  state    <= S_FRAME_B;
                  cs_pin   <= 1'b0;
                  clk_pin  <= 1'b0;
                  data_pin <= 1'b1;   // MSB of frame B is the channel bit, 1
                  div_cnt  <= '0;
                  bit_cnt  <= BIT_W'(15);
                  phase    <= 1'b0;
               end else begin
                  div_cnt <= div_cnt + CNT_W'(1);
               end
            end

            S_LDAC: begin
               if (div_cnt == CNT_W'(LDAC_W - 1)) begin
                  state    <= S_IDLE;
                  ldac_pin <= 1'b1;
                  ready    <= 1'b1;
                  div_cnt  <= '0;
               end else begin
                  div_cnt <= div_cnt + CNT_W'(1);
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dac_spi_writer.sv
// -----------------------------------------------------------------------------
// tb_dac_spi_writer
//   Two instances: a slow one (CLK_DIV=2, GAP=2, LDAC_W=2) and a fast one
//   (CLK_DIV=1, GAP=1, LDAC_W=1). Drivers push expected frame words and beam
//   values into per-instance queues at each handshake; one monitor process
//   decodes the SPI pins and pops/compares independently.
// -----------------------------------------------------------------------------
module tb_dac_spi_writer;

   localparam bit TB_BUF  = 1'b0;
   localparam bit TB_GA_N = 1'b1;

   logic        clk;
   logic        rst  [2];
   logic [11:0] xi   [2];
   logic [11:0] yi   [2];
   logic        bi   [2];
   logic        vld  [2];
   logic        rdy  [2];
   logic        cs   [2];
   logic        sck  [2];
   logic        dat  [2];
   logic        ldac [2];
   logic        beam [2];

   int errors = 0;
   int checks = 0;

   logic [15:0] exp_frame [2][$];
   logic        exp_beam  [2][$];

   dac_spi_writer #(.CLK_DIV(2), .GAP(2), .LDAC_W(2), .BUF(TB_BUF), .GA_N(TB_GA_N)) dut_slow (
      .clk(clk), .reset(rst[0]), .x(xi[0]), .y(yi[0]), .beam_in(bi[0]), .valid(vld[0]),
      .ready(rdy[0]), .cs_pin(cs[0]), .clk_pin(sck[0]), .data_pin(dat[0]),
      .ldac_pin(ldac[0]), .beam_pin(beam[0]));

   dac_spi_writer #(.CLK_DIV(1), .GAP(1), .LDAC_W(1), .BUF(TB_BUF), .GA_N(TB_GA_N)) dut_fast (
      .clk(clk), .reset(rst[1]), .x(xi[1]), .y(yi[1]), .beam_in(bi[1]), .valid(vld[1]),
      .ready(rdy[1]), .cs_pin(cs[1]), .clk_pin(sck[1]), .data_pin(dat[1]),
      .ldac_pin(ldac[1]), .beam_pin(beam[1]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int cd(input int g);
      return (g == 0) ? 2 : 1;
   endfunction
   function automatic int gp(input int g);
      return (g == 0) ? 2 : 1;
   endfunction
   function automatic int lw(input int g);
      return (g == 0) ? 2 : 1;
   endfunction
   function automatic int busy(input int g);
      return 64 * cd(g) + gp(g) + lw(g);
   endfunction

   // Reference frame: channel in bit 15, BUF in 14, GA_n in 13, SHDN_n=1 in 12
   function automatic logic [15:0] frame(input int ch, input logic [11:0] d);
      int v;
      v = ch * 32768 + int'(TB_BUF) * 16384 + int'(TB_GA_N) * 8192 + 4096 + int'(d);
      return 16'(v);
   endfunction

   task automatic check(input bit ok, input string name, input logic [31:0] act,
                        input logic [31:0] expv);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic check_reset_pins(input int g);
      check(cs[g] == 1'b1,   "rst_cs",    32'(cs[g]),   1);
      check(sck[g] == 1'b0,  "rst_sck",   32'(sck[g]),  0);
      check(dat[g] == 1'b0,  "rst_data",  32'(dat[g]),  0);
      check(ldac[g] == 1'b1, "rst_ldac",  32'(ldac[g]), 1);
      check(beam[g] == 1'b0, "rst_beam",  32'(beam[g]), 0);
      check(rdy[g] == 1'b0,  "rst_ready", 32'(rdy[g]),  0);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input int g, input logic [11:0] xv, input logic [11:0] yv,
                       input logic bv, output int waits);
      waits  = 0;
      vld[g] = 1'b1;
      xi[g]  = xv;
      yi[g]  = yv;
      bi[g]  = bv;
      while (!rdy[g] && waits < 2000) begin
         @(negedge clk);
         waits++;
      end
      check(rdy[g] == 1'b1, "accept_timeout", 32'(waits), 32'(busy(g)));
      if (rdy[g]) begin
         exp_frame[g].push_back(frame(0, xv));
         exp_frame[g].push_back(frame(1, yv));
         exp_beam[g].push_back(bv);
         @(negedge clk);
      end else begin
         vld[g] = 1'b0;
      end
   endtask

   // Scramble inputs and pulse valid while busy; drop valid once ready returns.
   task automatic busy_noise(input int g);
      int n = 0;
      while (!rdy[g] && n < 2000) begin
         vld[g] = 1'($urandom);
         xi[g]  = 12'($urandom);
         yi[g]  = 12'($urandom);
         bi[g]  = 1'($urandom);
         @(negedge clk);
         n++;
      end
      vld[g] = 1'b0;
      check(rdy[g] == 1'b1, "noise_timeout", 32'(n), 32'(busy(g)));
   endtask

   task automatic wait_idle(input int g);
      int n = 0;
      while (!rdy[g] && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check(rdy[g] == 1'b1, "idle_timeout", 32'(n), 32'(busy(g)));
   endtask

   // ---------------------------------------------------------------- monitor
   logic        p_cs [2], p_sck [2], p_rdy [2], p_ldac [2], p_beam [2];
   logic        low_data [2];
   logic [15:0] shreg [2];
   int          nbits [2], cs_cnt [2], rdy_cnt [2], ldac_cnt [2];
   bit          busy_on [2];

   initial begin
      logic [15:0] ef;
      logic        eb;
      forever begin
         @(negedge clk);
         for (int g = 0; g < 2; g++) begin
            if (rst[g]) begin
               p_cs[g] = 1'b1; p_sck[g] = 1'b0; p_rdy[g] = 1'b0;
               p_ldac[g] = 1'b1; p_beam[g] = 1'b0;
               nbits[g] = 0; cs_cnt[g] = 0; rdy_cnt[g] = 0; ldac_cnt[g] = 0;
               busy_on[g] = 1'b0; shreg[g] = '0; low_data[g] = 1'b0;
            end else begin
               if (cs[g]) check(sck[g] == 1'b0, "sck_low_while_cs_high", 32'(sck[g]), 0);

               // SPI frame decode
               if (p_cs[g] && !cs[g]) begin
                  nbits[g] = 0; cs_cnt[g] = 0; low_data[g] = dat[g];
               end
               if (!cs[g]) begin
                  cs_cnt[g]++;
                  if (p_sck[g] && !sck[g]) low_data[g] = dat[g];
                  if (!p_sck[g] && sck[g]) begin
                     check(dat[g] == low_data[g], "setup_data_stable", 32'(dat[g]),
                           32'(low_data[g]));
                     shreg[g] = {shreg[g][14:0], dat[g]};
                     nbits[g]++;
                  end
               end
               if (!p_cs[g] && cs[g]) begin
                  check(nbits[g] == 16, "sck_rising_edges", 32'(nbits[g]), 16);
                  check(cs_cnt[g] == 32 * cd(g), "cs_low_clocks", 32'(cs_cnt[g]),
                        32'(32 * cd(g)));
                  check(exp_frame[g].size() > 0, "frame_expected", 32'(shreg[g]), 0);
                  if (exp_frame[g].size() > 0) begin
                     ef = exp_frame[g].pop_front();
                     check(shreg[g] == ef, "frame_word", 32'(shreg[g]), 32'(ef));
                  end
               end

               // ready low duration per sample
               if (p_rdy[g] && !rdy[g]) begin busy_on[g] = 1'b1; rdy_cnt[g] = 0; end
               if (!rdy[g] && busy_on[g]) rdy_cnt[g]++;
               if (!p_rdy[g] && rdy[g] && busy_on[g]) begin
                  check(rdy_cnt[g] == busy(g), "ready_low_clocks", 32'(rdy_cnt[g]),
                        32'(busy(g)));
                  busy_on[g] = 1'b0;
               end

               // LDAC strobe and beam update
               if (beam[g] != p_beam[g])
                  check(p_ldac[g] && !ldac[g], "beam_change_outside_ldac", 32'(beam[g]),
                        32'(p_beam[g]));
               if (p_ldac[g] && !ldac[g]) begin
                  ldac_cnt[g] = 0;
                  check(exp_beam[g].size() > 0, "ldac_expected", 32'(ldac[g]), 1);
                  if (exp_beam[g].size() > 0) begin
                     eb = exp_beam[g].pop_front();
                     check(beam[g] == eb, "beam_at_ldac", 32'(beam[g]), 32'(eb));
                  end
               end
               if (!ldac[g]) ldac_cnt[g]++;
               if (!p_ldac[g] && ldac[g])
                  check(ldac_cnt[g] == lw(g), "ldac_low_clocks", 32'(ldac_cnt[g]),
                        32'(lw(g)));

               p_cs[g] = cs[g]; p_sck[g] = sck[g]; p_rdy[g] = rdy[g];
               p_ldac[g] = ldac[g]; p_beam[g] = beam[g];
            end
         end
      end
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      int w;
      for (int g = 0; g < 2; g++) begin
         rst[g] = 1'b0; vld[g] = 1'b0; xi[g] = '0; yi[g] = '0; bi[g] = 1'b0;
      end
      #2;
      rst[0] = 1'b1;
      rst[1] = 1'b1;
      #1;
      check_reset_pins(0);
      check_reset_pins(1);
      repeat (3) @(negedge clk);
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      @(negedge clk);
      check(rdy[0] == 1'b1, "ready_rise_slow", 32'(rdy[0]), 1);
      check(rdy[1] == 1'b1, "ready_rise_fast", 32'(rdy[1]), 1);

      // Directed sample: frames 3ABC then B123, beam 1
      send(0, 12'hABC, 12'h123, 1'b1, w);
      vld[0] = 1'b0;
      wait_idle(0);

      // valid held high: second sample accepted on the first ready cycle
      send(0, 12'h000, 12'hFFF, 1'b0, w);
      send(0, 12'hFFF, 12'h000, 1'b1, w);
      check(w == busy(0), "back_to_back_accept", 32'(w), 32'(busy(0)));
      vld[0] = 1'b0;
      wait_idle(0);

      // Inputs and valid churn while busy
      for (int i = 0; i < 4; i++) begin
         send(0, 12'($urandom), 12'($urandom), 1'($urandom), w);
         busy_noise(0);
      end

      // Abort during bit 7 of frame B
      send(0, 12'h5A5, 12'hA5A, 1'b1, w);
      vld[0] = 1'b0;
      wait_idle(0);
      send(0, 12'($urandom), 12'($urandom), 1'b0, w);
      vld[0] = 1'b0;
      repeat (99) @(negedge clk);
      #2;
      rst[0] = 1'b1;
      #1;
      check_reset_pins(0);
      exp_frame[0].delete();
      exp_beam[0].delete();
      @(negedge clk);
      @(negedge clk);
      rst[0] = 1'b0;
      @(negedge clk);
      check(rdy[0] == 1'b1, "ready_after_abort", 32'(rdy[0]), 1);
      send(0, 12'h3C3, 12'hC3C, 1'b1, w);
      vld[0] = 1'b0;
      wait_idle(0);

      // Fast instance: SCK toggles every clock
      send(1, 12'($urandom), 12'($urandom), 1'b1, w);
      send(1, 12'($urandom), 12'($urandom), 1'b0, w);
      check(w == busy(1), "fast_back_to_back_accept", 32'(w), 32'(busy(1)));
      busy_noise(1);
      for (int i = 0; i < 3; i++) begin
         send(1, 12'($urandom), 12'($urandom), 1'($urandom), w);
         vld[1] = 1'b0;
         wait_idle(1);
      end

      repeat (5) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         check(exp_frame[g].size() == 0, "frames_outstanding", 32'(exp_frame[g].size()), 0);
         check(exp_beam[g].size() == 0, "ldac_outstanding", 32'(exp_beam[g].size()), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
